// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional bounds checking is enabled with PC_BOUNDS_EN.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_IDLE,
      PC_RUN,
      PC_HALTED
   } pc_state_t;

   localparam int PC_INC = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the sequencer and its driver.
// Widths follow the sequencer parameters D and CW.
interface pc_sequencer_if #(
   parameter int D  = 12,
   parameter int CW = 16
);
   logic          start;
   logic          stall;
   logic          branch_en;
   logic          halt;
   logic [D-1:0]  target;
   logic [D-1:0]  prog_ctr;
   logic          running;
   logic          done;
   logic          err;
   logic [CW-1:0] instr_count;

   modport master (
      output start, stall, branch_en, halt, target,
      input  prog_ctr, running, done, err, instr_count
   );

   modport slave (
      input  start, stall, branch_en, halt, target,
      output prog_ctr, running, done, err, instr_count
   );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC adder; flags out-of-range targets when
// PC_BOUNDS_EN is defined, otherwise wraps modulo 2^D.
module pc_next_calc
   import pc_pkg::*;
#(
`ifdef PC_BOUNDS_EN
   parameter int PROG_LEN = 4096,
`endif
   parameter int D = 12
) (
   input  logic [D-1:0] prog_ctr,
   input  logic [D-1:0] target,
   input  logic         branch_en,
   output logic [D-1:0] next_pc,
   output logic         out_of_range
);

`ifdef PC_BOUNDS_EN
   // One extra bit keeps the sign; any overflow lands negative.
   logic signed [D:0] sum_s;
   logic signed [D:0] step_s;

   always_comb begin
      step_s = (D+1)'(PC_INC);
      if (branch_en) step_s = $signed({target[D-1], target});
      sum_s = $signed({1'b0, prog_ctr}) + step_s;
      next_pc = sum_s[D-1:0];
      out_of_range = (sum_s < 0) || (int'(sum_s) >= PROG_LEN);
   end
`else
   logic [D-1:0] step;

   always_comb begin
      step = D'(PC_INC);
      if (branch_en) step = target;
      next_pc = prog_ctr + step;
      out_of_range = 1'b0;
   end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PC register stage with start/halt sequencing and retired-instruction
// counter. Define PC_BOUNDS_EN to halt with err on out-of-range PC.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int D          = 12,
   parameter int START_ADDR = 0,
`ifdef PC_BOUNDS_EN
   parameter int PROG_LEN   = 4096,
`endif
   parameter int CW         = 16
) (
   input logic          clk,
   input logic          reset,
   pc_sequencer_if.slave bus
);

   localparam logic [D-1:0] START_PC = D'(START_ADDR);

   pc_state_t     state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [D-1:0]  next_pc;
   logic          oor;
   logic [CW-1:0] cnt_inc;

   pc_next_calc #(
`ifdef PC_BOUNDS_EN
      .PROG_LEN (PROG_LEN),
`endif
      .D        (D)
   ) u_next (
      .prog_ctr     (pc_q),
      .target       (bus.target),
      .branch_en    (bus.branch_en),
      .next_pc      (next_pc),
      .out_of_range (oor)
   );

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         PC_IDLE, PC_HALTED: begin
            if (bus.start) begin
               state_d = PC_RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         PC_RUN: begin
            if (bus.halt) begin
               state_d = PC_HALTED;
               cnt_d   = cnt_inc;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else if (oor) begin
               state_d = PC_HALTED;
               err_d   = 1'b1;
               cnt_d   = cnt_inc;
            end else begin
               pc_d  = next_pc;
               cnt_d = cnt_inc;
            end
         end
         default: state_d = PC_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PC_IDLE;
         pc_q    <= START_PC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus.prog_ctr    = pc_q;
   assign bus.instr_count = cnt_q;
   assign bus.running     = (state_q == PC_RUN);
   assign bus.done        = (state_q == PC_HALTED);
   assign bus.err         = err_q;

endmodule
